// File: rtl/alu_multicycle_exec.sv
// Execute stage: single-cycle MOVI/MOV/ADD/SUB, iterative shift-add MULT and
// restoring DIV, with a valid/ready handshake to stall upstream during long ops.
module alu_multicycle_exec #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             zero,
  output logic             div_by_zero,
  output logic             out_valid
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  typedef enum logic [3:0] {
    OP_MOVI = 4'b0000,
    OP_MOV  = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0110,
    OP_MULT = 4'b1000,
    OP_DIV  = 4'b1001
  } op_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, a_reg, b_reg;
  logic             is_div;
  logic             accept, fin, fin_dbz, ge;
  logic [WIDTH-1:0] fin_res, fin_rem;
  logic [WIDTH:0]   shifted, diff;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;

  // MUL: acc = product, a_reg = shifting multiplicand, b_reg = shifting multiplier.
  // DIV: acc = partial remainder, a_reg = dividend shifting out / quotient in, b_reg = divisor.
  assign shifted = {acc, a_reg[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, b_reg});
  assign diff    = shifted - {1'b0, b_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) begin
        if (alu_control == OP_MULT)                     state_n = MUL;
        else if (alu_control == OP_DIV && op_b != '0)   state_n = DIV;
      end
      MUL, DIV: if (cnt == CW'(1)) state_n = DONE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    fin     = 1'b0;
    fin_res = '0;
    fin_rem = '0;
    fin_dbz = 1'b0;
    if (state == DONE) begin
      fin = 1'b1;
      if (is_div) begin
        fin_res = a_reg;
        fin_rem = acc;
      end else begin
        fin_res = acc;
      end
    end else if (accept) begin
      case (alu_control)
        OP_MOVI: begin fin = 1'b1; fin_res = op_b;        end
        OP_MOV:  begin fin = 1'b1; fin_res = op_a;        end
        OP_ADD:  begin fin = 1'b1; fin_res = op_a + op_b; end
        OP_SUB:  begin fin = 1'b1; fin_res = op_a - op_b; end
        OP_MULT: fin = 1'b0;
        OP_DIV: begin
          if (op_b == '0) begin
            fin     = 1'b1;
            fin_res = '1;
            fin_rem = op_a;
            fin_dbz = 1'b1;
          end
        end
        default: begin fin = 1'b1; fin_res = '0; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      is_div <= 1'b0;
    end else if (accept) begin
      cnt    <= CW'(WIDTH);
      acc    <= '0;
      a_reg  <= op_a;
      b_reg  <= op_b;
      is_div <= (alu_control == OP_DIV);
    end else if (state == MUL) begin
      acc   <= acc + (b_reg[0] ? a_reg : '0);
      a_reg <= a_reg << 1;
      b_reg <= b_reg >> 1;
      cnt   <= cnt - CW'(1);
    end else if (state == DIV) begin
      acc   <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      a_reg <= {a_reg[WIDTH-2:0], ge};
      cnt   <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result      <= '0;
      remainder   <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= fin;
      if (fin) begin
        result      <= fin_res;
        remainder   <= fin_rem;
        zero        <= (fin_res == '0);
        div_by_zero <= fin_dbz;
      end
    end
  end

endmodule
